// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the memory-side interconnect: arbiter state encoding and
// the physical-memory line geometry.
package lc3b_types;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } pmem_arb_state_t;

   localparam int PMEM_LINE_ADDR_W = 12;
   localparam int PMEM_LINE_DATA_W = 128;

endpackage

// File: rtl/pmem_arbiter_rr_pick.sv
// Combinational round-robin picker: first pending index at or after ptr_i,
// wrapping modulo N. Returns a one-hot grant and its index.
module rr_pick #(
   parameter int N  = 3,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  pend_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   logic found;
   int   j;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      j     = 0;
      for (int k = 0; k < N; k++) begin
         j = (int'(ptr_i) + k) % N;
         if (!found && pend_i[j]) begin
            found    = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = IW'(j);
         end
      end
   end

   assign any_o = |pend_i;

endmodule

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing one Wishbone master port to pmem between the
// eviction (0), fill (1) and stream (2) requesters; one transaction per grant.
module pmem_arbiter
   import lc3b_types::*;
#(
   parameter int NUM_REQ = 3,
   parameter int ADDR_W  = PMEM_LINE_ADDR_W,
   parameter int DATA_W  = PMEM_LINE_DATA_W,
   parameter int SEL_W   = DATA_W / 8,
   parameter int TIMEOUT = 1023,
   parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_cyc,
   input  logic [NUM_REQ-1:0]        req_stb,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ*SEL_W-1:0]  req_sel,
   input  logic [NUM_REQ*ADDR_W-1:0] req_adr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        req_ack,
   output logic [NUM_REQ-1:0]        req_rty,
   output logic [DATA_W-1:0]         req_rdata,
   output logic                      pm_cyc,
   output logic                      pm_stb,
   output logic                      pm_we,
   output logic [SEL_W-1:0]          pm_sel,
   output logic [ADDR_W-1:0]         pm_adr,
   output logic [DATA_W-1:0]         pm_wdata,
   input  logic                      pm_ack,
   input  logic                      pm_rty,
   input  logic [DATA_W-1:0]         pm_rdata,
   output logic [IW-1:0]             grant_id,
   output logic                      err_timeout
);

   localparam int CW = $clog2(TIMEOUT + 1);

   pmem_arb_state_t      state_q, state_d;
   logic [IW-1:0]        ptr_q, ptr_d, gid_q, gid_d;
   logic                 cyc_q, cyc_d, we_q, we_d;
   logic [SEL_W-1:0]     sel_q, sel_d;
   logic [ADDR_W-1:0]    adr_q, adr_d;
   logic [DATA_W-1:0]    wdat_q, wdat_d, rdata_q, rdata_d;
   logic [NUM_REQ-1:0]   ack_q, ack_d, rty_q, rty_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 err_q, err_d, abn_q, abn_d;

   logic [NUM_REQ-1:0]   pend, pick_gnt, gid_oh;
   logic [IW-1:0]        pick_idx, ptr_nxt;
   logic                 pick_any, gone;
   logic                 m_we;
   logic [SEL_W-1:0]     m_sel;
   logic [ADDR_W-1:0]    m_adr;
   logic [DATA_W-1:0]    m_wdat;

   assign pend = req_cyc & req_stb;

   rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
      .pend_i (pend),
      .ptr_i  (ptr_q),
      .gnt_o  (pick_gnt),
      .idx_o  (pick_idx),
      .any_o  (pick_any)
   );

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_oh
      assign gid_oh[i] = (gid_q == IW'(i));
   end

   // One-hot AND-OR mux of the winning requester's command fields.
   always_comb begin
      m_we   = 1'b0;
      m_sel  = '0;
      m_adr  = '0;
      m_wdat = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_gnt[i]) begin
            m_we   = req_we[i];
            m_sel  = req_sel[i*SEL_W +: SEL_W];
            m_adr  = req_adr[i*ADDR_W +: ADDR_W];
            m_wdat = req_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   assign ptr_nxt = (gid_q == IW'(NUM_REQ - 1)) ? '0 : gid_q + IW'(1);
   // Grantee is considered gone once its STB drops at any point in BUSY.
   assign gone    = abn_q | ~|(gid_oh & pend);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gid_d   = gid_q;
      cyc_d   = cyc_q;
      we_d    = we_q;
      sel_d   = sel_q;
      adr_d   = adr_q;
      wdat_d  = wdat_q;
      rdata_d = rdata_q;
      ack_d   = '0;
      rty_d   = '0;
      cnt_d   = cnt_q;
      err_d   = err_q;
      abn_d   = abn_q;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               gid_d   = pick_idx;
               we_d    = m_we;
               sel_d   = m_sel;
               adr_d   = m_adr;
               wdat_d  = m_wdat;
               cyc_d   = 1'b1;
               cnt_d   = '0;
               abn_d   = 1'b0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q != CW'(TIMEOUT)) cnt_d = cnt_q + CW'(1);
            if (cnt_d == CW'(TIMEOUT)) err_d = 1'b1;
            abn_d = gone;
            if (pm_ack || pm_rty) begin
               cyc_d   = 1'b0;
               ptr_d   = ptr_nxt;
               state_d = DONE;
               if (!gone) begin
                  if (pm_ack) begin
                     ack_d   = gid_oh;
                     rdata_d = pm_rdata;
                  end else begin
                     rty_d = gid_oh;
                  end
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         gid_q   <= '0;
         cyc_q   <= 1'b0;
         we_q    <= 1'b0;
         sel_q   <= '0;
         adr_q   <= '0;
         wdat_q  <= '0;
         ack_q   <= '0;
         rty_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         abn_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gid_q   <= gid_d;
         cyc_q   <= cyc_d;
         we_q    <= we_d;
         sel_q   <= sel_d;
         adr_q   <= adr_d;
         wdat_q  <= wdat_d;
         ack_q   <= ack_d;
         rty_q   <= rty_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         abn_q   <= abn_d;
      end
   end

   // Read data is only meaningful alongside req_ack, so it carries no reset.
   always_ff @(posedge clk) begin
      rdata_q <= rdata_d;
   end

   assign req_ack     = ack_q;
   assign req_rty     = rty_q;
   assign req_rdata   = rdata_q;
   assign pm_cyc      = cyc_q;
   assign pm_stb      = cyc_q;
   assign pm_we       = we_q;
   assign pm_sel      = sel_q;
   assign pm_adr      = adr_q;
   assign pm_wdata    = wdat_q;
   assign grant_id    = gid_q;
   assign err_timeout = err_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Scenario bench for pmem_arbiter; expected responses are queued when a
// request is issued and popped when the arbiter pulses ACK/RTY.
module tb_pmem_arbiter;

   localparam int N  = 3;
   localparam int AW = 12;
   localparam int DW = 128;
   localparam int SW = 16;

   typedef struct {
      int           id;
      bit           is_ack;
      logic [DW-1:0] data;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_cyc, req_stb, req_we;
   logic [N*SW-1:0] req_sel;
   logic [N*AW-1:0] req_adr;
   logic [N*DW-1:0] req_wdata;
   logic [N-1:0]    req_ack, req_rty;
   logic [DW-1:0]   req_rdata;
   logic            pm_cyc, pm_stb, pm_we;
   logic [SW-1:0]   pm_sel;
   logic [AW-1:0]   pm_adr;
   logic [DW-1:0]   pm_wdata;
   logic            pm_ack, pm_rty;
   logic [DW-1:0]   pm_rdata;
   logic [1:0]      grant_id;
   logic            err_timeout;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   pmem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .SEL_W(SW), .TIMEOUT(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_cyc(req_cyc), .req_stb(req_stb), .req_we(req_we), .req_sel(req_sel),
      .req_adr(req_adr), .req_wdata(req_wdata),
      .req_ack(req_ack), .req_rty(req_rty), .req_rdata(req_rdata),
      .pm_cyc(pm_cyc), .pm_stb(pm_stb), .pm_we(pm_we), .pm_sel(pm_sel),
      .pm_adr(pm_adr), .pm_wdata(pm_wdata),
      .pm_ack(pm_ack), .pm_rty(pm_rty), .pm_rdata(pm_rdata),
      .grant_id(grant_id), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1ns after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_inputs();
      req_cyc = '0; req_stb = '0; req_we = '0;
      req_sel = '0; req_adr = '0; req_wdata = '0;
      pm_ack = 1'b0; pm_rty = 1'b0; pm_rdata = '0;
   endtask

   task automatic do_reset();
      clr_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic set_req(input int id, input logic we, input logic [SW-1:0] sel,
                          input logic [AW-1:0] adr, input logic [DW-1:0] wd);
      req_cyc[id] = 1'b1;
      req_stb[id] = 1'b1;
      req_we[id]  = we;
      req_sel[id*SW +: SW]   = sel;
      req_adr[id*AW +: AW]   = adr;
      req_wdata[id*DW +: DW] = wd;
   endtask

   task automatic wait_stb(output int c);
      c = 0;
      while (!pm_stb && c < 20) begin
         tick();
         c++;
      end
   endtask

   task automatic test_reset();
      exp_t e;
      int c;
      clr_inputs();
      rst_n   = 1'b0;
      req_cyc = 3'b111;
      req_stb = 3'b111;
      for (int k = 0; k < 2; k++) begin
         tick();
         total++;
         if ({pm_cyc, pm_stb, pm_we, pm_sel, pm_adr, pm_wdata, req_ack, req_rty, err_timeout, grant_id} !== '0) begin
            bad++;
            $display("FAIL reset_outputs cyc%0d: cyc=%b stb=%b we=%b sel=%h adr=%h ack=%b rty=%b err=%b gid=%0d want all 0",
                     k, pm_cyc, pm_stb, pm_we, pm_sel, pm_adr, req_ack, req_rty, err_timeout, grant_id);
         end
      end
      rst_n = 1'b1;
      wait_stb(c);
      total++;
      if (pm_stb !== 1'b1 || grant_id !== 2'd0 || c != 1) begin
         bad++;
         $display("FAIL reset_first_grant: stb=%b gid=%0d wait=%0d want stb=1 gid=0 wait=1", pm_stb, grant_id, c);
      end
      sb.push_back('{0, 1'b1, 128'h5});
      pm_ack = 1'b1; pm_rdata = 128'h5;
      tick();
      pm_ack = 1'b0; req_cyc = '0; req_stb = '0;
      e = sb.pop_front();
      total++;
      if (req_ack !== (3'b001 << e.id) || req_rdata !== e.data) begin
         bad++;
         $display("FAIL reset_first_ack: ack=%b data=%h want ack=%b data=%h", req_ack, req_rdata, 3'b001 << e.id, e.data);
      end
      tick();
   endtask

   task automatic test_single_read();
      exp_t e;
      logic [DW-1:0] d;
      d = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
      set_req(1, 1'b0, 16'h0, 12'h0A5, '0);
      tick();
      total++;
      if (pm_stb !== 1'b1 || pm_cyc !== 1'b1 || pm_adr !== 12'h0A5 || pm_we !== 1'b0 || grant_id !== 2'd1) begin
         bad++;
         $display("FAIL read_issue: stb=%b cyc=%b adr=%h we=%b gid=%0d want 1 1 0a5 0 1", pm_stb, pm_cyc, pm_adr, pm_we, grant_id);
      end
      sb.push_back('{1, 1'b1, d});
      for (int k = 0; k < 3; k++) begin
         tick();
         total++;
         if (req_ack !== 3'b000 || pm_stb !== 1'b1) begin
            bad++;
            $display("FAIL read_wait%0d: ack=%b stb=%b want ack=000 stb=1", k, req_ack, pm_stb);
         end
      end
      pm_ack = 1'b1; pm_rdata = d;
      tick();
      pm_ack = 1'b0; pm_rdata = '0;
      e = sb.pop_front();
      total++;
      if (req_ack !== (3'b001 << e.id) || req_rdata !== e.data || pm_stb !== 1'b0) begin
         bad++;
         $display("FAIL read_ack: ack=%b data=%h stb=%b want ack=%b data=%h stb=0", req_ack, req_rdata, pm_stb, 3'b001 << e.id, e.data);
      end
      req_cyc = '0; req_stb = '0;
      tick();
      total++;
      if (req_ack !== 3'b000 || pm_stb !== 1'b0) begin
         bad++;
         $display("FAIL read_pulse_width: ack=%b stb=%b want ack=000 stb=0", req_ack, pm_stb);
      end
   endtask

   task automatic test_round_robin();
      exp_t e;
      int c;
      do_reset();
      for (int i = 0; i < N; i++) set_req(i, 1'b0, 16'h0, AW'(12'h100 + i), '0);
      for (int g = 0; g < 6; g++) begin
         wait_stb(c);
         total++;
         if (grant_id !== 2'(g % N) || pm_adr !== AW'(12'h100 + g % N) || c != 1) begin
            bad++;
            $display("FAIL rr_grant%0d: gid=%0d adr=%h wait=%0d want gid=%0d adr=%h wait=1",
                     g, grant_id, pm_adr, c, g % N, 12'h100 + g % N);
         end
         sb.push_back('{g % N, 1'b1, DW'(g + 32'hA0)});
         pm_ack = 1'b1; pm_rdata = DW'(g + 32'hA0);
         tick();
         pm_ack = 1'b0;
         e = sb.pop_front();
         total++;
         if (req_ack !== (3'b001 << e.id) || req_rdata !== e.data || pm_stb !== 1'b0) begin
            bad++;
            $display("FAIL rr_ack%0d: ack=%b data=%h stb=%b want ack=%b data=%h stb=0",
                     g, req_ack, req_rdata, pm_stb, 3'b001 << e.id, e.data);
         end
         tick();
      end
      clr_inputs();
      tick();
   endtask

   task automatic test_write();
      exp_t e;
      int c;
      logic [DW-1:0] wd;
      wd = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      set_req(0, 1'b1, 16'hFFFF, 12'h3F0, wd);
      wait_stb(c);
      sb.push_back('{0, 1'b1, 128'h0});
      // Requester fields change mid-BUSY; pmem side must not follow.
      req_wdata[0 +: DW] = ~wd;
      req_sel[0 +: SW]   = 16'h00F0;
      req_we[0]          = 1'b0;
      for (int k = 0; k < 3; k++) begin
         total++;
         if (pm_we !== 1'b1 || pm_sel !== 16'hFFFF || pm_wdata !== wd || pm_adr !== 12'h3F0 || pm_stb !== 1'b1) begin
            bad++;
            $display("FAIL write_hold%0d: we=%b sel=%h adr=%h wdata=%h want 1 ffff 3f0 %h", k, pm_we, pm_sel, pm_adr, pm_wdata, wd);
         end
         tick();
      end
      pm_ack = 1'b1;
      tick();
      pm_ack = 1'b0;
      e = sb.pop_front();
      total++;
      if (req_ack !== (3'b001 << e.id) || req_rty !== 3'b000) begin
         bad++;
         $display("FAIL write_ack: ack=%b rty=%b want ack=%b rty=000", req_ack, req_rty, 3'b001 << e.id);
      end
      clr_inputs();
      tick();
   endtask

   task automatic test_rty();
      exp_t e;
      int c;
      set_req(2, 1'b0, 16'h0, 12'h3C3, '0);
      wait_stb(c);
      sb.push_back('{2, 1'b0, 128'h0});
      pm_rty = 1'b1;
      tick();
      pm_rty = 1'b0;
      e = sb.pop_front();
      total++;
      if (req_rty !== (3'b001 << e.id) || req_ack !== 3'b000) begin
         bad++;
         $display("FAIL rty_only: rty=%b ack=%b want rty=%b ack=000", req_rty, req_ack, 3'b001 << e.id);
      end
      wait_stb(c);
      sb.push_back('{2, 1'b1, 128'hC0FFEE});
      pm_ack = 1'b1; pm_rty = 1'b1; pm_rdata = 128'hC0FFEE;
      tick();
      pm_ack = 1'b0; pm_rty = 1'b0;
      e = sb.pop_front();
      total++;
      if (req_ack !== (3'b001 << e.id) || req_rty !== 3'b000 || req_rdata !== e.data) begin
         bad++;
         $display("FAIL ack_rty_collision: ack=%b rty=%b data=%h want ack=%b rty=000 data=%h",
                  req_ack, req_rty, req_rdata, 3'b001 << e.id, e.data);
      end
      clr_inputs();
      tick();
   endtask

   task automatic test_abandon();
      exp_t e;
      int c;
      do_reset();
      set_req(1, 1'b0, 16'h0, 12'h055, '0);
      wait_stb(c);
      tick();
      req_stb[1] = 1'b0;
      tick();
      pm_ack = 1'b1;
      tick();
      pm_ack = 1'b0;
      total++;
      if (req_ack !== 3'b000 || req_rty !== 3'b000 || pm_stb !== 1'b0) begin
         bad++;
         $display("FAIL abandon_suppress: ack=%b rty=%b stb=%b want 000 000 0", req_ack, req_rty, pm_stb);
      end
      tick();
      req_cyc = 3'b111; req_stb = 3'b111;
      wait_stb(c);
      total++;
      if (grant_id !== 2'd2) begin
         bad++;
         $display("FAIL abandon_ptr_advance: gid=%0d want 2", grant_id);
      end
      sb.push_back('{2, 1'b1, 128'h77});
      pm_ack = 1'b1; pm_rdata = 128'h77;
      tick();
      pm_ack = 1'b0;
      clr_inputs();
      e = sb.pop_front();
      total++;
      if (req_ack !== (3'b001 << e.id) || req_rdata !== e.data) begin
         bad++;
         $display("FAIL abandon_next_ack: ack=%b data=%h want ack=%b data=%h", req_ack, req_rdata, 3'b001 << e.id, e.data);
      end
      tick();
   endtask

   task automatic test_watchdog();
      exp_t e;
      int c;
      set_req(0, 1'b0, 16'h0, 12'h7FF, '0);
      wait_stb(c);
      // The 8th BUSY cycle brings the count to TIMEOUT; the flag is set at its closing edge.
      for (int k = 1; k <= 8; k++) begin
         tick();
         total++;
         if (err_timeout !== (k >= 8)) begin
            bad++;
            $display("FAIL watchdog_edge%0d: err=%b want %b", k, err_timeout, k >= 8);
         end
      end
      tick();
      tick();
      total++;
      if (err_timeout !== 1'b1 || pm_stb !== 1'b1) begin
         bad++;
         $display("FAIL watchdog_hold: err=%b stb=%b want err=1 stb=1", err_timeout, pm_stb);
      end
      sb.push_back('{0, 1'b1, 128'h99});
      pm_ack = 1'b1; pm_rdata = 128'h99;
      tick();
      pm_ack = 1'b0;
      clr_inputs();
      e = sb.pop_front();
      total++;
      if (req_ack !== (3'b001 << e.id) || req_rdata !== e.data) begin
         bad++;
         $display("FAIL watchdog_late_ack: ack=%b data=%h want ack=%b data=%h", req_ack, req_rdata, 3'b001 << e.id, e.data);
      end
      tick();
      tick();
      total++;
      if (err_timeout !== 1'b1) begin
         bad++;
         $display("FAIL watchdog_sticky: err=%b want 1", err_timeout);
      end
      do_reset();
      total++;
      if (err_timeout !== 1'b0 || sb.size() != 0) begin
         bad++;
         $display("FAIL watchdog_reset_clear: err=%b sb_left=%0d want err=0 sb_left=0", err_timeout, sb.size());
      end
   endtask

   initial begin
      clr_inputs();
      rst_n = 1'b0;
      test_reset();
      test_single_read();
      test_round_robin();
      test_write();
      test_rty();
      test_abandon();
      test_watchdog();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
